// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Optional feature macro: HAZARD_DETECT_EN (undefined = plain enable/flush pipeline register).
module id_ex_stage #(
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc_plus4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [31:0]       ex_pc_plus4,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_rdata1,
    output logic [31:0]       ex_rdata2,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_wr_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              valid_q,   valid_d;
    logic [31:0]       pc_q,      pc_d;
    logic [31:0]       imm_q,     imm_d;
    logic [31:0]       rdata1_q,  rdata1_d;
    logic [31:0]       rdata2_q,  rdata2_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        shamt_q,   shamt_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic              hazard;
    logic              bubble;

`ifdef HAZARD_DETECT_EN
    // A load in EX whose destination is read by the ID instruction must wait one cycle.
    assign hazard = valid_q & ctrl_q[1] & (rt_q != 5'd0) & id_valid &
                    ((id_uses_rs & (id_rs == rt_q)) | (id_uses_rt & (id_rt == rt_q)));
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = id_uses_rs ^ id_uses_rt;
    assign hazard = 1'b0;
`endif

    assign stall_out = hazard & ~flush;
    assign bubble    = flush | stall_out;

    always_comb begin
        valid_d   = 1'b0;
        pc_d      = '0;
        imm_d     = '0;
        rdata1_d  = '0;
        rdata2_d  = '0;
        rs_d      = '0;
        rt_d      = '0;
        shamt_d   = '0;
        wr_addr_d = '0;
        ctrl_d    = '0;
        if (!bubble) begin
            valid_d   = id_valid;
            pc_d      = id_pc_plus4;
            imm_d     = id_imm;
            rdata1_d  = id_rdata1;
            rdata2_d  = id_rdata2;
            rs_d      = id_rs;
            rt_d      = id_rt;
            shamt_d   = id_shamt;
            wr_addr_d = id_ctrl[5] ? id_rd : id_rt;
            ctrl_d    = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            shamt_q   <= '0;
            wr_addr_q <= '0;
            ctrl_q    <= '0;
        end else if (enable) begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            shamt_q   <= shamt_d;
            wr_addr_q <= wr_addr_d;
            ctrl_q    <= ctrl_d;
        end
    end

`ifdef HAZARD_DETECT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate rather than wrap so the count stays a lower bound on stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (enable && stall_out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

    assign ex_valid    = valid_q;
    assign ex_pc_plus4 = pc_q;
    assign ex_imm      = imm_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_shamt    = shamt_q;
    assign ex_wr_addr  = wr_addr_q;
    assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the HAZARD_DETECT_EN build setting.
module tb_id_ex_stage;

    localparam int CTRL_W = 9;
    localparam int CNT_W  = 3;
`ifdef HAZARD_DETECT_EN
    localparam bit HazardOn = 1'b1;
`else
    localparam bit HazardOn = 1'b0;
`endif
    localparam logic [CTRL_W-1:0] CtrlLoad = 9'h00B;
    localparam logic [CTRL_W-1:0] CtrlAluR = 9'h021;
    localparam logic [CTRL_W-1:0] CtrlAluI = 9'h001;

    logic              clk = 1'b0;
    logic              reset, enable, flush, id_valid;
    logic [31:0]       id_pc_plus4, id_imm, id_rdata1, id_rdata2;
    logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_uses_rs, id_uses_rt;
    logic              stall_out, ex_valid;
    logic [31:0]       ex_pc_plus4, ex_imm, ex_rdata1, ex_rdata2;
    logic [4:0]        ex_rs, ex_rt, ex_shamt, ex_wr_addr;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_count;

    int compared   = 0;
    int mismatched = 0;
    int expCount   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_imm(id_imm), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_ctrl(id_ctrl), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
        .ex_imm(ex_imm), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt),
        .ex_wr_addr(ex_wr_addr), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [CTRL_W-1:0] ctrl, input logic urs, input logic urt);
        id_valid    = v;
        id_pc_plus4 = pc;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_shamt    = rd ^ 5'd1;
        id_imm      = imm;
        id_rdata1   = pc ^ 32'hA5A5_0000;
        id_rdata2   = imm ^ 32'h0000_5A5A;
        id_ctrl     = ctrl;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        #1;
    endtask

    // Bench-side model of the saturating counter.
    task automatic expectStall();
        if (HazardOn && expCount < 7) expCount++;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        flush  = 1'b0;
        reset  = 1'b1;
        setId(1'b1, 32'h0000_1234, 5'd5, 5'd6, 5'd7, 32'hDEAD_BEEF, CtrlLoad, 1'b1, 1'b1);
        step();
        enable = 1'b0;
        step();
        compared++;
        if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", ex_valid); end
        compared++;
        if (ex_ctrl !== '0) begin mismatched++; $display("[TB] FAIL reset_ctrl got %h want 0", ex_ctrl); end
        compared++;
        if ({ex_pc_plus4, ex_imm, ex_rdata1, ex_rdata2} !== 128'd0) begin
            mismatched++; $display("[TB] FAIL reset_data got %h %h want 0", ex_pc_plus4, ex_imm);
        end
        compared++;
        if ({ex_rs, ex_rt, ex_shamt, ex_wr_addr} !== 20'd0) begin
            mismatched++; $display("[TB] FAIL reset_addr got %h %h want 0", ex_rt, ex_wr_addr);
        end
        compared++;
        if (stall_count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count got %0d want 0", stall_count); end
        compared++;
        if (stall_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall got %b want 0", stall_out); end
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_pass_through();
        setId(1'b1, 32'h0000_0104, 5'd2, 5'd3, 5'd7, 32'hFFFF_8888, CtrlAluR, 1'b1, 1'b1);
        step();
        compared++;
        if (ex_imm !== 32'hFFFF_8888) begin mismatched++; $display("[TB] FAIL pass_imm got %h want ffff8888", ex_imm); end
        compared++;
        if (ex_wr_addr !== 5'd7) begin mismatched++; $display("[TB] FAIL pass_wr_rd got %0d want 7", ex_wr_addr); end
        compared++;
        if (ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL pass_valid got %b want 1", ex_valid); end
        compared++;
        if (ex_ctrl !== CtrlAluR) begin mismatched++; $display("[TB] FAIL pass_ctrl got %h want %h", ex_ctrl, CtrlAluR); end
        compared++;
        if ({ex_pc_plus4, ex_rdata1, ex_rdata2} !== {32'h0000_0104, 32'hA5A5_0104, 32'hFFFF_D2D2}) begin
            mismatched++; $display("[TB] FAIL pass_data got %h %h %h want 00000104 a5a50104 ffffd2d2", ex_pc_plus4, ex_rdata1, ex_rdata2);
        end
        compared++;
        if ({ex_rs, ex_rt, ex_shamt} !== {5'd2, 5'd3, 5'd6}) begin
            mismatched++; $display("[TB] FAIL pass_fields got %0d %0d %0d want 2 3 6", ex_rs, ex_rt, ex_shamt);
        end
        setId(1'b1, 32'h0000_0108, 5'd2, 5'd3, 5'd7, 32'h0000_0042, CtrlAluI, 1'b1, 1'b0);
        step();
        compared++;
        if (ex_wr_addr !== 5'd3) begin mismatched++; $display("[TB] FAIL pass_wr_rt got %0d want 3", ex_wr_addr); end
        setId(1'b0, 32'h0000_010C, 5'd4, 5'd8, 5'd9, 32'h0000_0077, CtrlAluR, 1'b1, 1'b1);
        step();
        compared++;
        if ({ex_valid, ex_ctrl} !== {1'b0, 9'h000}) begin
            mismatched++; $display("[TB] FAIL pass_invalid got %b %h want 0 000", ex_valid, ex_ctrl);
        end
        compared++;
        if (ex_pc_plus4 !== 32'h0000_010C) begin mismatched++; $display("[TB] FAIL pass_invalid_pc got %h want 0000010c", ex_pc_plus4); end
    endtask

    task automatic test_load_use();
        setId(1'b1, 32'h0000_0200, 5'd1, 5'd5, 5'd0, 32'h0000_0010, CtrlLoad, 1'b1, 1'b0);
        step();
        setId(1'b1, 32'h0000_0204, 5'd5, 5'd9, 5'd10, 32'h0000_0020, CtrlAluR, 1'b1, 1'b0);
        compared++;
        if (stall_out !== HazardOn) begin mismatched++; $display("[TB] FAIL lu_stall got %b want %b", stall_out, HazardOn); end
        expectStall();
        step();
        compared++;
        if (ex_valid !== !HazardOn) begin mismatched++; $display("[TB] FAIL lu_bubble got %b want %b", ex_valid, !HazardOn); end
        compared++;
        if (stall_count !== 3'(expCount)) begin mismatched++; $display("[TB] FAIL lu_count got %0d want %0d", stall_count, expCount); end
        compared++;
        if (stall_out !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_stall_clear got %b want 0", stall_out); end
        step();
        compared++;
        if ({ex_valid, ex_rs, ex_wr_addr} !== {1'b1, 5'd5, 5'd10}) begin
            mismatched++; $display("[TB] FAIL lu_reload got %b %0d %0d want 1 5 10", ex_valid, ex_rs, ex_wr_addr);
        end
        // rt-side match and a non-reading rs match
        setId(1'b1, 32'h0000_0300, 5'd1, 5'd12, 5'd0, 32'h0000_0004, CtrlLoad, 1'b1, 1'b0);
        step();
        setId(1'b1, 32'h0000_0304, 5'd12, 5'd3, 5'd4, 32'h0, CtrlAluR, 1'b0, 1'b0);
        compared++;
        if (stall_out !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_unused_rs got %b want 0", stall_out); end
        setId(1'b1, 32'h0000_0304, 5'd3, 5'd12, 5'd4, 32'h0, CtrlAluR, 1'b1, 1'b1);
        compared++;
        if (stall_out !== HazardOn) begin mismatched++; $display("[TB] FAIL lu_rt_match got %b want %b", stall_out, HazardOn); end
        expectStall();
        step();
        step();
    endtask

    task automatic test_zero_register();
        setId(1'b1, 32'h0000_0400, 5'd1, 5'd0, 5'd0, 32'h0, CtrlLoad, 1'b1, 1'b0);
        step();
        setId(1'b1, 32'h0000_0404, 5'd0, 5'd0, 5'd6, 32'h0, CtrlAluR, 1'b1, 1'b1);
        compared++;
        if (stall_out !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_stall got %b want 0", stall_out); end
        step();
        compared++;
        if ({ex_valid, ex_wr_addr} !== {1'b1, 5'd6}) begin
            mismatched++; $display("[TB] FAIL zero_nobubble got %b %0d want 1 6", ex_valid, ex_wr_addr);
        end
        compared++;
        if (stall_count !== 3'(expCount)) begin mismatched++; $display("[TB] FAIL zero_count got %0d want %0d", stall_count, expCount); end
    endtask

    task automatic test_flush_hazard();
        setId(1'b1, 32'h0000_0500, 5'd1, 5'd5, 5'd0, 32'h0, CtrlLoad, 1'b1, 1'b0);
        step();
        flush = 1'b1;
        setId(1'b1, 32'h0000_0504, 5'd5, 5'd2, 5'd8, 32'h0000_0055, CtrlAluR, 1'b1, 1'b1);
        compared++;
        if (stall_out !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stall got %b want 0", stall_out); end
        step();
        flush = 1'b0;
        compared++;
        if ({ex_valid, ex_ctrl, ex_pc_plus4, ex_imm} !== {1'b0, 9'h000, 64'd0}) begin
            mismatched++; $display("[TB] FAIL flush_bubble got %b %h %h want 0 000 0", ex_valid, ex_ctrl, ex_pc_plus4);
        end
        compared++;
        if (stall_count !== 3'(expCount)) begin mismatched++; $display("[TB] FAIL flush_count got %0d want %0d", stall_count, expCount); end
    endtask

    task automatic test_enable_low();
        setId(1'b1, 32'h0000_0600, 5'd1, 5'd5, 5'd0, 32'h0000_0010, CtrlLoad, 1'b1, 1'b0);
        step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setId(1'b1, 32'h0000_0700 + 32'(i), 5'd5, 5'(i), 5'd9, 32'h0000_1000 + 32'(i), CtrlAluR, 1'b1, 1'b1);
            compared++;
            if (stall_out !== HazardOn) begin mismatched++; $display("[TB] FAIL hold_stall[%0d] got %b want %b", i, stall_out, HazardOn); end
            step();
            compared++;
            if ({ex_valid, ex_rt, ex_ctrl, ex_imm, ex_pc_plus4} !== {1'b1, 5'd5, CtrlLoad, 32'h0000_0010, 32'h0000_0600}) begin
                mismatched++; $display("[TB] FAIL hold_regs[%0d] got %b %0d %h %h want 1 5 00b 00000010", i, ex_valid, ex_rt, ex_ctrl, ex_imm);
            end
            compared++;
            if (stall_count !== 3'(expCount)) begin mismatched++; $display("[TB] FAIL hold_count[%0d] got %0d want %0d", i, stall_count, expCount); end
        end
        enable = 1'b1;
        expectStall();
        step();
        step();
        compared++;
        if (stall_count !== 3'(expCount)) begin mismatched++; $display("[TB] FAIL hold_resume got %0d want %0d", stall_count, expCount); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            setId(1'b1, 32'h0000_0800, 5'd1, 5'd7, 5'd0, 32'h0, CtrlLoad, 1'b1, 1'b0);
            step();
            setId(1'b1, 32'h0000_0804, 5'd7, 5'd2, 5'd3, 32'h0, CtrlAluR, 1'b1, 1'b0);
            expectStall();
            step();
        end
        compared++;
        if (stall_count !== (HazardOn ? 3'd7 : 3'd0)) begin
            mismatched++; $display("[TB] FAIL sat_count got %0d want %0d", stall_count, HazardOn ? 7 : 0);
        end
    endtask

    task automatic test_reset_mid_stall();
        setId(1'b1, 32'h0000_0900, 5'd1, 5'd5, 5'd0, 32'h0, CtrlLoad, 1'b1, 1'b0);
        step();
        setId(1'b1, 32'h0000_0904, 5'd5, 5'd2, 5'd3, 32'h0, CtrlAluR, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expCount = 0;
        compared++;
        if ({ex_valid, ex_ctrl, stall_count, stall_out} !== {1'b0, 9'h000, 3'd0, 1'b0}) begin
            mismatched++; $display("[TB] FAIL midreset got %b %h %0d %b want 0 000 0 0", ex_valid, ex_ctrl, stall_count, stall_out);
        end
        step();
        compared++;
        if ({ex_valid, ex_rs, ex_wr_addr} !== {1'b1, 5'd5, 5'd3}) begin
            mismatched++; $display("[TB] FAIL midreset_fresh got %b %0d %0d want 1 5 3", ex_valid, ex_rs, ex_wr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_zero_register();
        test_flush_hazard();
        test_enable_low();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
